// File: rtl/kb_pkg.sv
// Shared keypad types, widths and column/row index encoding helpers.
// Latency: none (types and pure functions only).
// Backpressure: none.
package kb_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kb_state_t;

    localparam int IDX_W      = 2;
    localparam int KEY_CODE_W = 2 * IDX_W;
    localparam int POS_W      = 3;
    localparam int CNT_W      = 4;

    localparam logic [3:0] COL_IDLE = 4'b1111;
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    function automatic logic [3:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [3:0] v;
        case (idx)
            2'd0:    v = 4'b0111;
            2'd1:    v = 4'b1011;
            2'd2:    v = 4'b1101;
            default: v = 4'b1110;
        endcase
        return v;
    endfunction

    // Lowest index wins when several lines are low.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [3:0] pat);
        logic [IDX_W-1:0] idx;
        if (!pat[3])      idx = 2'd0;
        else if (!pat[2]) idx = 2'd1;
        else if (!pat[1]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

    function automatic logic code_is_x(input logic [KEY_CODE_W-1:0] code);
        return code[KEY_CODE_W-1];
    endfunction

endpackage

// File: rtl/keypad_pos_latch.sv
// Latches board X/Y coordinates from accepted key codes, with set flags.
// Latency: 1 clk from key_valid / pos_clear to updated outputs.
// Backpressure: none; every key_valid is absorbed.
module keypad_pos_latch
    import kb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    input  logic [KEY_CODE_W-1:0] key_code,
    input  logic                  pos_clear,
    output logic [POS_W-1:0]      pos_x,
    output logic [POS_W-1:0]      pos_y,
    output logic                  pos_x_set,
    output logic                  pos_y_set
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x     <= '0;
            pos_y     <= '0;
            pos_x_set <= 1'b0;
            pos_y_set <= 1'b0;
        end else begin
            if (pos_clear) begin
                pos_x_set <= 1'b0;
                pos_y_set <= 1'b0;
            end
            // A key arriving with a clear wins for its own flag.
            if (key_valid) begin
                if (code_is_x(key_code)) begin
                    pos_x     <= key_code[POS_W-1:0];
                    pos_x_set <= 1'b1;
                end else begin
                    pos_y     <= key_code[POS_W-1:0];
                    pos_y_set <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce, release filter and coordinate latch.
// Latency: key_valid 1 clk after the scan_tick that completes debounce.
// Backpressure: none; events are single-clk pulses, scan paced only by scan_tick.
module keypad_scanner
    import kb_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int RELEASE_TICKS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_tick,
    input  logic                  enable,
    input  logic [3:0]            keyboard_row,
    output logic [3:0]            keyboard_col,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_held,
    output logic [POS_W-1:0]      pos_x,
    output logic [POS_W-1:0]      pos_y,
    output logic                  pos_x_set,
    output logic                  pos_y_set,
    input  logic                  pos_clear
);

    localparam logic [CNT_W-1:0] DB_T  = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] REL_T = CNT_W'(RELEASE_TICKS);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    kb_state_t        state;
    logic [IDX_W-1:0] col_idx;
    logic [IDX_W-1:0] col_nxt;
    logic [3:0]       row_pat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             rows_idle;

    assign col_nxt   = col_idx + 1'b1;
    assign cnt_inc   = cnt + 1'b1;
    assign rows_idle = (row_sync == ROW_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= ROW_IDLE;
            row_sync <= ROW_IDLE;
        end else begin
            row_meta <= keyboard_row;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SCAN;
            col_idx      <= '0;
            keyboard_col <= idx_to_onehot('0);
            row_pat      <= ROW_IDLE;
            cnt          <= '0;
            key_valid    <= 1'b0;
            key_code     <= '0;
            key_held     <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (!enable) begin
                state        <= SCAN;
                col_idx      <= '0;
                keyboard_col <= COL_IDLE;
                cnt          <= '0;
                key_held     <= 1'b0;
            end else begin
                keyboard_col <= idx_to_onehot(col_idx);
                if (scan_tick) begin
                    case (state)
                        SCAN: begin
                            if (!rows_idle) begin
                                row_pat <= row_sync;
                                if (DB_T == CNT_W'(1)) begin
                                    key_valid <= 1'b1;
                                    key_code  <= {onehot_to_idx(row_sync), col_idx};
                                    key_held  <= 1'b1;
                                    cnt       <= '0;
                                    state     <= HELD;
                                end else begin
                                    cnt   <= CNT_W'(1);
                                    state <= DEBOUNCE;
                                end
                            end else begin
                                col_idx      <= col_nxt;
                                keyboard_col <= idx_to_onehot(col_nxt);
                            end
                        end
                        DEBOUNCE: begin
                            if (row_sync == row_pat) begin
                                if (cnt_inc == DB_T) begin
                                    key_valid <= 1'b1;
                                    key_code  <= {onehot_to_idx(row_sync), col_idx};
                                    key_held  <= 1'b1;
                                    cnt       <= '0;
                                    state     <= HELD;
                                end else begin
                                    cnt <= cnt_inc;
                                end
                            end else begin
                                // Pattern changed: rescan the same column.
                                cnt   <= '0;
                                state <= SCAN;
                            end
                        end
                        HELD: begin
                            if (rows_idle) begin
                                if (cnt_inc == REL_T) begin
                                    cnt          <= '0;
                                    key_held     <= 1'b0;
                                    col_idx      <= col_nxt;
                                    keyboard_col <= idx_to_onehot(col_nxt);
                                    state        <= SCAN;
                                end else begin
                                    cnt <= cnt_inc;
                                end
                            end else begin
                                cnt <= '0;
                            end
                        end
                        default: begin
                            cnt   <= '0;
                            state <= SCAN;
                        end
                    endcase
                end
            end
        end
    end

    keypad_pos_latch u_pos_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .pos_clear (pos_clear),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .pos_x_set (pos_x_set),
        .pos_y_set (pos_y_set)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model, vector table, corner sequences, random episodes.
// Latency: n/a.  Backpressure: n/a.
module tb_keypad_scanner;

    localparam int DB  = 4;
    localparam int REL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scan_tick;
    logic        enable;
    logic [3:0]  keyboard_row;
    logic [3:0]  keyboard_col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [2:0]  pos_x;
    logic [2:0]  pos_y;
    logic        pos_x_set;
    logic        pos_y_set;
    logic        pos_clear;

    logic [15:0] keys_down;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ev_cnt  = 0;
    logic [3:0]  ev_code = 4'h0;
    logic [3:0]  colmap [4];

    typedef struct {
        logic [15:0] keys;
        int          hold;
        int          gap;
        bit          clr;
        int          exp_ev;
        logic [3:0]  exp_code;
        logic [2:0]  exp_x;
        logic [2:0]  exp_y;
        bit          exp_xs;
        bit          exp_ys;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    keypad_scanner #(.DEBOUNCE_TICKS(DB), .RELEASE_TICKS(REL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_tick    (scan_tick),
        .enable       (enable),
        .keyboard_row (keyboard_row),
        .keyboard_col (keyboard_col),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_held     (key_held),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .pos_x_set    (pos_x_set),
        .pos_y_set    (pos_y_set),
        .pos_clear    (pos_clear)
    );

    // Key k sits at row k/4, column k%4; a driven-low column pulls its pressed rows low.
    always_comb begin
        keyboard_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_down[r*4+c] && !keyboard_col[3-c]) keyboard_row[3-r] = 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            ev_cnt  = ev_cnt + 1;
            ev_code = key_code;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        repeat (7) @(posedge clk);
        #1 scan_tick = 1'b1;
        @(posedge clk);
        #1 scan_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_clear();
        pos_clear = 1'b1;
        clk1();
        pos_clear = 1'b0;
    endtask

    task automatic do_reset();
        keys_down = '0;
        pos_clear = 1'b0;
        scan_tick = 1'b0;
        enable    = 1'b1;
        rst_n     = 1'b0;
        clk1();
        clk1();
        rst_n = 1'b1;
        clk1();
    endtask

    initial begin
        int ev0;
        int col;
        bit hit;
        logic [2:0] mx, my;
        bit mxs, mys;

        colmap[0] = 4'b0111; colmap[1] = 4'b1011; colmap[2] = 4'b1101; colmap[3] = 4'b1110;

        vecs[0] = '{16'h8000, 10, 6, 1'b0, 1, 4'hF, 3'd7, 3'd0, 1'b1, 1'b0};
        vecs[1] = '{16'h0004, 10, 6, 1'b0, 1, 4'h2, 3'd7, 3'd2, 1'b1, 1'b1};
        vecs[2] = '{16'h0000,  2, 4, 1'b1, 0, 4'h0, 3'd7, 3'd2, 1'b0, 1'b0};
        vecs[3] = '{16'h0100, 10, 6, 1'b0, 1, 4'h8, 3'd0, 3'd2, 1'b1, 1'b0};
        vecs[4] = '{16'h0080, 10, 6, 1'b0, 1, 4'h7, 3'd0, 3'd7, 1'b1, 1'b1};

        // Reset values.
        keys_down = '0; pos_clear = 1'b0; scan_tick = 1'b0; enable = 1'b1; rst_n = 1'b1;
        #2 rst_n = 1'b0;
        clk1(); clk1();
        check("rst keyboard_col", 32'(keyboard_col), 32'h7);
        check("rst key_valid", 32'(key_valid), 0);
        check("rst key_code", 32'(key_code), 0);
        check("rst key_held", 32'(key_held), 0);
        check("rst pos", 32'({pos_x, pos_y, pos_x_set, pos_y_set}), 0);
        rst_n = 1'b1;
        clk1();

        // Idle scan walks the columns.
        ev0 = ev_cnt;
        check("scan col0", 32'(keyboard_col), 32'(colmap[0]));
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("scan col tick%0d", i), 32'(keyboard_col), 32'(colmap[i%4]));
        end
        clk1();
        check("scan no events", 32'(ev_cnt - ev0), 0);

        // Vector table.
        foreach (vecs[v]) begin
            ev0 = ev_cnt;
            if (vecs[v].clr) pulse_clear();
            keys_down = vecs[v].keys;
            ticks(vecs[v].hold);
            keys_down = '0;
            for (int g = 1; g <= vecs[v].gap; g++) begin
                tick();
                if (g == REL - 1) check($sformatf("v%0d held before release", v), 32'(key_held), 32'(vecs[v].exp_ev));
                if (g == REL)     check($sformatf("v%0d held after release", v), 32'(key_held), 0);
            end
            clk1();
            check($sformatf("v%0d events", v), 32'(ev_cnt - ev0), 32'(vecs[v].exp_ev));
            if (vecs[v].exp_ev != 0) check($sformatf("v%0d code", v), 32'(ev_code), 32'(vecs[v].exp_code));
            check($sformatf("v%0d pos_x", v), 32'(pos_x), 32'(vecs[v].exp_x));
            check($sformatf("v%0d pos_y", v), 32'(pos_y), 32'(vecs[v].exp_y));
            check($sformatf("v%0d pos_x_set", v), 32'(pos_x_set), 32'(vecs[v].exp_xs));
            check($sformatf("v%0d pos_y_set", v), 32'(pos_y_set), 32'(vecs[v].exp_ys));
        end

        // pos_clear in the same clk as key_valid for key 9.
        keys_down = 16'h0200;
        hit = 1'b0;
        for (int i = 0; i < 12 && !hit; i++) begin
            tick();
            if (key_valid) begin
                pulse_clear();
                hit = 1'b1;
            end
        end
        check("coincide event seen", 32'(hit), 1);
        clk1();
        check("coincide pos_x", 32'(pos_x), 1);
        check("coincide pos_x_set", 32'(pos_x_set), 1);
        check("coincide pos_y_set", 32'(pos_y_set), 0);
        check("coincide pos_y", 32'(pos_y), 7);
        keys_down = '0;
        ticks(6);

        // Bouncing key 2: accepted on the 4th tick after the bounce.
        do_reset();
        ticks(2);
        check("bounce start col", 32'(keyboard_col), 32'(colmap[2]));
        ev0 = ev_cnt;
        keys_down = 16'h0004;
        ticks(2);
        keys_down = '0;
        tick();
        keys_down = 16'h0004;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 4)  check($sformatf("bounce early tick%0d", i), 32'(key_valid), 0);
            if (i == 4) begin
                check("bounce accept tick", 32'(key_valid), 1);
                clk1();
                check("bounce pulse width", 32'(key_valid), 0);
            end
        end
        check("bounce events", 32'(ev_cnt - ev0), 1);
        check("bounce code", 32'(ev_code), 32'h2);
        check("bounce pos_y", 32'(pos_y), 2);
        check("bounce pos_y_set", 32'(pos_y_set), 1);
        keys_down = '0;
        ticks(6);

        // Keys 4 and 5 together: column 0 reached first.
        do_reset();
        ev0 = ev_cnt;
        keys_down = 16'h0030;
        ticks(14);
        check("dual events held", 32'(ev_cnt - ev0), 1);
        check("dual code", 32'(ev_code), 32'h4);
        keys_down = '0;
        ticks(3);
        check("dual held 3 after", 32'(key_held), 1);
        tick();
        check("dual held 4 after", 32'(key_held), 0);
        ticks(4);
        check("dual events final", 32'(ev_cnt - ev0), 1);

        // enable dropped during debounce.
        do_reset();
        ev0 = ev_cnt;
        keys_down = 16'h0001;
        ticks(2);
        enable = 1'b0;
        clk1();
        check("disable col idle", 32'(keyboard_col), 32'hF);
        check("disable held", 32'(key_held), 0);
        ticks(5);
        check("disable no event", 32'(ev_cnt - ev0), 0);
        enable = 1'b1;
        clk1();
        check("reenable col0", 32'(keyboard_col), 32'(colmap[0]));
        ticks(3);
        check("reenable no early event", 32'(ev_cnt - ev0), 0);
        tick();
        check("reenable accept", 32'(key_valid), 1);
        clk1();
        check("reenable code", 32'(key_code), 0);
        check("reenable pos_y_set", 32'(pos_y_set), 1);
        keys_down = '0;
        ticks(6);

        // Reset mid-HELD with the key still down.
        do_reset();
        keys_down = 16'h8000;
        hit = 1'b0;
        for (int i = 0; i < 12 && !hit; i++) begin
            tick();
            hit = key_held;
        end
        check("midheld reached", 32'(hit), 1);
        ticks(2);
        rst_n = 1'b0;
        #1;
        check("midrst col", 32'(keyboard_col), 32'h7);
        check("midrst held", 32'(key_held), 0);
        check("midrst code", 32'(key_code), 0);
        check("midrst pos", 32'({pos_x, pos_x_set}), 0);
        clk1();
        rst_n = 1'b1;
        ev0 = ev_cnt;
        ticks(12);
        check("midrst events", 32'(ev_cnt - ev0), 1);
        check("midrst new code", 32'(ev_code), 32'hF);
        check("midrst held again", 32'(key_held), 1);
        keys_down = '0;
        ticks(6);
        check("midrst events final", 32'(ev_cnt - ev0), 1);

        // Random single-key episodes against the arithmetic scan model.
        do_reset();
        col = 0; mx = '0; my = '0; mxs = 1'b0; mys = 1'b0;
        for (int ep = 0; ep < 40; ep++) begin
            int k, kc, h, g, d;
            bit acc, clr;
            k   = $urandom_range(0, 15);
            h   = $urandom_range(1, 10);
            g   = $urandom_range(REL, REL + 3);
            clr = ($urandom_range(0, 3) == 0);
            kc  = k % 4;
            d   = (kc - col + 4) % 4;
            acc = (h >= d + DB);
            if (clr) begin
                pulse_clear();
                mxs = 1'b0;
                mys = 1'b0;
            end
            ev0 = ev_cnt;
            keys_down = '0;
            keys_down[k] = 1'b1;
            ticks(h);
            keys_down = '0;
            ticks(g);
            clk1();
            if (acc) begin
                col = (kc + 1 + g - REL) % 4;
                if (k >= 8) begin mx = 3'(k % 8); mxs = 1'b1; end
                else        begin my = 3'(k % 8); mys = 1'b1; end
            end else if (h <= d) begin
                col = (col + h + g) % 4;
            end else begin
                col = (kc + g - 1) % 4;
            end
            check($sformatf("rnd%0d events", ep), 32'(ev_cnt - ev0), 32'(acc));
            if (acc) check($sformatf("rnd%0d code", ep), 32'(ev_code), 32'(k));
            check($sformatf("rnd%0d pos", ep), 32'({pos_x, pos_y, pos_x_set, pos_y_set}), 32'({mx, my, mxs, mys}));
            check($sformatf("rnd%0d col", ep), 32'(keyboard_col), 32'(colmap[col]));
            check($sformatf("rnd%0d held", ep), 32'(key_held), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
